// File: rtl/nco_pkg.sv
// Shared constants and types for the NCO phase accumulator.
// NCO_WIDTH is the default accumulator/FCW width (multiple of 8); NCO_HALF is
// the width of each pipelined adder half (multiple of 4).
package nco_pkg;

    localparam int NCO_WIDTH = 32;
    localparam int NCO_HALF  = NCO_WIDTH / 2;

    typedef logic [NCO_WIDTH-1:0] phase_t;
    typedef logic [NCO_WIDTH-1:0] fcw_t;
    typedef logic [NCO_HALF-1:0]  half_t;

endpackage

// File: rtl/cla_n_bit.sv
// N-bit carry-lookahead adder built from 4-bit CLA slices plus a group
// lookahead over the slice propagate/generate terms.
// Ports:
//   a, b  in   N  addends
//   cin   in   1  carry in
//   sum   out  N  a + b + cin (mod 2^N)
//   cout  out  1  carry out of bit N-1
module cla_n_bit #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int SLICES = N / 4;

    logic [N-1:0]      g;
    logic [N-1:0]      p;
    logic [N-1:0]      c;    // carry into each bit
    logic [SLICES-1:0] pg;   // slice group propagate
    logic [SLICES-1:0] gg;   // slice group generate
    logic [SLICES:0]   sc;   // carry into each slice

    assign g = a & b;
    assign p = a ^ b;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        localparam int B = 4 * s;

        assign pg[s] = &p[B+3:B];
        assign gg[s] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        // In-slice lookahead: every bit carry comes straight from the slice carry-in.
        assign c[B]   = sc[s];
        assign c[B+1] = g[B] | (p[B] & sc[s]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & sc[s]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & sc[s]);
    end

    // Group lookahead across slices.
    always_comb begin
        sc[0] = cin;
        for (int s = 0; s < SLICES; s++) begin
            sc[s+1] = gg[s] | (pg[s] & sc[s]);
        end
    end

    assign sum  = p ^ c;
    assign cout = sc[SLICES];

endmodule

// File: rtl/nco_phase_accum.sv
// NCO phase accumulator: each enabled cycle the phase advances by the FCW,
// modulo 2^WIDTH. The add is split into a low and a high half with a
// registered carry between them; the low half runs one step ahead, and the
// output pairs the high half with a delayed copy of the low half so the
// visible phase is always coherent (one step behind the low accumulator).
// Ports:
//   clk        in   1      clock, all state on posedge
//   rst        in   1      asynchronous active-high reset
//   en         in   1      advance enable
//   fcw_wr     in   1      load fcw_in into the FCW register
//   fcw_in     in   WIDTH  new frequency control word
//   phase_wr   in   1      load phase_in and restart the pipeline
//   phase_in   in   WIDTH  new phase value
//   phase_out  out  WIDTH  coherent accumulated phase (registered)
//   phase_vld  out  1      pipeline primed, phase_out advancing normally
//   rollover   out  1      one-cycle pulse when phase_out wrapped
module nco_phase_accum
    import nco_pkg::*;
#(
    parameter int WIDTH = NCO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fcw_wr,
    input  logic [WIDTH-1:0] fcw_in,
    input  logic             phase_wr,
    input  logic [WIDTH-1:0] phase_in,
    output logic [WIDTH-1:0] phase_out,
    output logic             phase_vld,
    output logic             rollover
);

    localparam int HALF = WIDTH / 2;

    logic [HALF-1:0] lo_acc;
    logic [HALF-1:0] lo_dly;
    logic [HALF-1:0] hi_acc;
    logic            carry_q;
    logic [HALF-1:0] fcw_lo;
    logic [HALF-1:0] fcw_hi;
    logic [HALF-1:0] fcw_hi_dly;   // fcw_hi that accompanied the pending low-half step
    logic            prime;        // high half not yet fed by a low-half step

    logic [HALF-1:0] lo_sum;
    logic            lo_cout;
    logic [HALF-1:0] hi_sum;
    logic            hi_cout;

    cla_n_bit #(.N(HALF)) u_lo_add (
        .a    (lo_acc),
        .b    (fcw_lo),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cla_n_bit #(.N(HALF)) u_hi_add (
        .a    (hi_acc),
        .b    (fcw_hi_dly),
        .cin  (carry_q),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values (lo_dly <= lo_acc relies on this).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_acc     <= '0;
            lo_dly     <= '0;
            hi_acc     <= '0;
            carry_q    <= 1'b0;
            fcw_lo     <= '0;
            fcw_hi     <= '0;
            fcw_hi_dly <= '0;
            prime      <= 1'b1;
            rollover   <= 1'b0;
        end else begin
            if (fcw_wr) begin
                {fcw_hi, fcw_lo} <= fcw_in;
            end

            if (phase_wr) begin
                lo_acc     <= phase_in[HALF-1:0];
                lo_dly     <= phase_in[HALF-1:0];
                hi_acc     <= phase_in[WIDTH-1:HALF];
                carry_q    <= 1'b0;
                rollover   <= 1'b0;
                prime      <= 1'b1;
                fcw_hi_dly <= fcw_wr ? fcw_in[WIDTH-1:HALF] : fcw_hi;
            end else if (en) begin
                lo_acc     <= lo_sum;
                carry_q    <= lo_cout;
                lo_dly     <= lo_acc;
                fcw_hi_dly <= fcw_hi;
                prime      <= 1'b0;
                if (prime) begin
                    // First step after a load: only the low half moves.
                    rollover <= 1'b0;
                end else begin
                    hi_acc   <= hi_sum;
                    rollover <= hi_cout;
                end
            end else begin
                rollover <= 1'b0;
            end
        end
    end

    assign phase_out = {hi_acc, lo_dly};
    assign phase_vld = ~prime;

endmodule

// File: tb/tb_nco_phase_accum.sv
module tb_nco_phase_accum;
    import nco_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   en;
    logic   fcw_wr;
    fcw_t   fcw_in;
    logic   phase_wr;
    phase_t phase_in;
    phase_t phase_out;
    logic   phase_vld;
    logic   rollover;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: full-width accumulator, output lags by one step.
    phase_t m_acc;    // phase after the most recent step
    phase_t m_out;    // visible phase
    fcw_t   m_fcw;    // FCW register
    fcw_t   m_step;   // FCW used by the most recent step
    logic   m_prime;
    logic   m_roll;

    nco_phase_accum #(.WIDTH(NCO_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fcw_wr    (fcw_wr),
        .fcw_in    (fcw_in),
        .phase_wr  (phase_wr),
        .phase_in  (phase_in),
        .phase_out (phase_out),
        .phase_vld (phase_vld),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc   = '0;
        m_out   = '0;
        m_fcw   = '0;
        m_step  = '0;
        m_prime = 1'b1;
        m_roll  = 1'b0;
    endtask

    task automatic model_edge();
        logic [32:0] s;
        if (phase_wr) begin
            m_acc   = phase_in;
            m_out   = phase_in;
            m_prime = 1'b1;
            m_roll  = 1'b0;
        end else if (en) begin
            if (m_prime) begin
                m_prime = 1'b0;
                m_roll  = 1'b0;
            end else begin
                s      = {1'b0, m_out} + {1'b0, m_step};
                m_roll = s[32];
                m_out  = m_acc;
            end
            m_step = m_fcw;
            m_acc  = m_acc + m_fcw;
        end else begin
            m_roll = 1'b0;
        end
        if (fcw_wr) m_fcw = fcw_in;
    endtask

    task automatic check_model();
        check("phase_out", phase_out, m_out);
        check("phase_vld", {31'b0, phase_vld}, {31'b0, ~m_prime});
        check("rollover", {31'b0, rollover}, {31'b0, m_roll});
    endtask

    // One clock: apply inputs, advance model at the edge, compare #1 later.
    task automatic tick(input logic e, input logic fw, input fcw_t fi,
                        input logic pw, input phase_t pi);
        en = e; fcw_wr = fw; fcw_in = fi; phase_wr = pw; phase_in = pi;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        en = 1'b0; fcw_wr = 1'b0; phase_wr = 1'b0;
    endtask

    task automatic step_en();
        tick(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        en = 0; fcw_wr = 0; fcw_in = '0; phase_wr = 0; phase_in = '0;
        rst = 1'b1;
        model_reset();
        #3;
        check("rst_phase", phase_out, 32'h0);
        check("rst_vld", {31'b0, phase_vld}, 32'h0);
        check("rst_roll", {31'b0, rollover}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Quarter-turn FCW from reset.
        tick(1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
        check("q_load", phase_out, 32'h0);
        step_en(); check("q_prime", phase_out, 32'h0);
        step_en(); check("q_1", phase_out, 32'h4000_0000);
        step_en(); check("q_2", phase_out, 32'h8000_0000);
        step_en(); check("q_3", phase_out, 32'hC000_0000);
        check("q_3_roll", {31'b0, rollover}, 32'h0);
        step_en(); check("q_wrap", phase_out, 32'h0);
        check("q_wrap_roll", {31'b0, rollover}, 32'h1);
        step_en(); check("q_after_roll", {31'b0, rollover}, 32'h0);

        // Carry across the half boundary.
        tick(1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_FFFF);
        check("x_load", phase_out, 32'h0000_FFFF);
        step_en(); check("x_prime", phase_out, 32'h0000_FFFF);
        step_en(); check("x_carry", phase_out, 32'h0001_0000);
        step_en(); check("x_next", phase_out, 32'h0001_0001);

        // FCW change mid-run.
        tick(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h1000_0000);
        step_en(); check("f_prime", phase_out, 32'h1000_0000);
        step_en(); check("f_1", phase_out, 32'h1000_0010);
        tick(1'b1, 1'b1, 32'h0001_0001, 1'b0, '0);
        check("f_2", phase_out, 32'h1000_0020);
        step_en(); check("f_3", phase_out, 32'h1000_0030);
        step_en(); check("f_new1", phase_out, 32'h1001_0031);
        step_en(); check("f_new2", phase_out, 32'h1002_0032);

        // Freeze with a pending low-half carry and an FCW write.
        tick(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_FFF0);
        step_en(); check("h_prime", phase_out, 32'h0000_FFF0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, (i == 2), 32'h0000_0001, 1'b0, '0);
            check("h_frozen", phase_out, 32'h0000_FFF0);
            check("h_frozen_roll", {31'b0, rollover}, 32'h0);
        end
        step_en(); check("h_resume1", phase_out, 32'h0001_0010);
        step_en(); check("h_resume2", phase_out, 32'h0001_0011);

        // Load and FCW write in the same cycle, wrapping on the first real step.
        tick(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'hFFFF_FFF0);
        check("w_load", phase_out, 32'hFFFF_FFF0);
        check("w_load_vld", {31'b0, phase_vld}, 32'h0);
        step_en(); check("w_prime", phase_out, 32'hFFFF_FFF0);
        check("w_prime_vld", {31'b0, phase_vld}, 32'h1);
        step_en(); check("w_wrap", phase_out, 32'h0);
        check("w_wrap_roll", {31'b0, rollover}, 32'h1);

        // Asynchronous reset mid-run.
        tick(1'b0, 1'b1, 32'h0123_4567, 1'b1, 32'h8765_4321);
        step_en(); step_en();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("ar_phase", phase_out, 32'h0);
        check("ar_vld", {31'b0, phase_vld}, 32'h0);
        check("ar_roll", {31'b0, rollover}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b0, '0);
        step_en(); check("ar_prime", phase_out, 32'h0);
        step_en(); check("ar_1", phase_out, 32'h0000_0100);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            tick($urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, fcw_t'($urandom),
                 $urandom_range(0, 19) == 0, phase_t'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
